// File: rtl/om_pkg.sv
// Shared types and default widths for the output-merger destination fetch path.
//   om_color_t      : 32-bit packed colour word
//   om_dst_entry_t  : one in-flight fragment held in the destination-fetch queue
package om_pkg;

    localparam int OM_ADDR_WIDTH  = 32;
    localparam int OM_XY_WIDTH    = 12;
    localparam int OM_PITCH_WIDTH = 16;
    localparam int OM_TAG_WIDTH   = 8;
    localparam int OM_QUEUE_DEPTH = 4;

    typedef logic [31:0] om_color_t;

    typedef struct packed {
        logic [OM_XY_WIDTH-1:0]  pos_x;
        logic [OM_XY_WIDTH-1:0]  pos_y;
        om_color_t               src_color;
        om_color_t               dst_color;
        logic [OM_TAG_WIDTH-1:0] tag;
        logic                    done;     // dst_color final, entry may leave
    } om_dst_entry_t;

endpackage

// File: rtl/om_dst_index_fifo.sv
// In-order FIFO of queue-entry indices whose destination reads have been issued.
// The head names the entry that the next memory response belongs to.
//   clk, reset : clock, synchronous active-low reset
//   push       : write push_idx (a request was accepted by memory)
//   push_idx   : queue index of the issued read
//   pop        : drop the head (its response arrived)
//   head_idx   : index at the head
//   empty      : no reads outstanding
module om_dst_index_fifo #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             pop,
    output logic [IDX_W-1:0] head_idx,
    output logic             empty
);

    logic [IDX_W-1:0] slots [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W:0]   count;

    assign head_idx = slots[rd_ptr];
    assign empty    = (count == '0);

    // NOTE: storage arrays are left unreset; only pointers and count carry reset,
    // so contents are never observed before being written.
    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= push_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + IDX_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + IDX_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (IDX_W+1)'(1);
                2'b01:   count <= count - (IDX_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/om_dst_fetch.sv
// Destination-colour reader for the output-merger blend stage.
// Accepts fragments, reads the framebuffer pixel under each one (when asked to)
// and presents {src_color, dst_color} to the blender strictly in input order.
//   clk, reset                     : clock, synchronous active-low reset
//   cbuf_addr, cbuf_pitch          : framebuffer base byte address and row pitch
//   in_*                           : fragment input (valid/ready handshake)
//   mem_req_*                      : read request (valid/ready), 4-byte aligned address
//   mem_rsp_valid, mem_rsp_data    : in-order read data, no back-pressure
//   out_*                          : fragment plus fetched colour (valid/ready)
module om_dst_fetch
    import om_pkg::*;
#(
    parameter int ADDR_WIDTH  = OM_ADDR_WIDTH,
    parameter int XY_WIDTH    = OM_XY_WIDTH,
    parameter int PITCH_WIDTH = OM_PITCH_WIDTH,
    parameter int TAG_WIDTH   = OM_TAG_WIDTH,
    parameter int QUEUE_DEPTH = OM_QUEUE_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  cbuf_addr,
    input  logic [PITCH_WIDTH-1:0] cbuf_pitch,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XY_WIDTH-1:0]    in_pos_x,
    input  logic [XY_WIDTH-1:0]    in_pos_y,
    input  om_color_t              in_src_color,
    input  logic                   in_read_en,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  om_color_t              mem_rsp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XY_WIDTH-1:0]    out_pos_x,
    output logic [XY_WIDTH-1:0]    out_pos_y,
    output om_color_t              out_src_color,
    output om_color_t              out_dst_color,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    om_dst_entry_t         queue [QUEUE_DEPTH];
    logic [IDX_W-1:0]      wr_ptr;
    logic [IDX_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [IDX_W-1:0]      req_idx;

    logic                  full;
    logic                  accept;
    logic                  pop;
    logic                  req_fire;
    logic                  rsp_hit;
    logic                  fifo_empty;
    logic [IDX_W-1:0]      fifo_head;
    logic [ADDR_WIDTH-1:0] addr_calc;
    om_dst_entry_t         head;
    om_dst_entry_t         new_entry;

    // A stalled request blocks new fragments: the request register has one slot.
    assign full     = (count == CNT_W'(QUEUE_DEPTH));
    assign in_ready = reset && !full && !(req_valid && !mem_req_ready);
    assign accept   = in_valid && in_ready;

    assign head      = queue[rd_ptr];
    assign out_valid = reset && (count != '0) && head.done;
    assign pop       = out_valid && out_ready;

    assign req_fire = req_valid && mem_req_ready;
    // Responses with nothing outstanding (stale reads from before a reset) are dropped.
    assign rsp_hit  = reset && mem_rsp_valid && !fifo_empty;

    assign mem_req_valid = req_valid;
    assign mem_req_addr  = req_addr;

    // Byte address of the pixel; all terms widened first so the sum wraps mod 2^ADDR_WIDTH.
    assign addr_calc = cbuf_addr
                     + ADDR_WIDTH'(in_pos_y) * ADDR_WIDTH'(cbuf_pitch)
                     + ADDR_WIDTH'({in_pos_x, 2'b00});

    // NOTE: every field gets a value before any branch so no latch can be inferred.
    always_comb begin
        new_entry           = '0;
        new_entry.pos_x     = in_pos_x;
        new_entry.pos_y     = in_pos_y;
        new_entry.src_color = in_src_color;
        new_entry.tag       = in_tag;
        new_entry.done      = !in_read_en;
    end

    // Accept writes the free slot at wr_ptr; a response targets a pending entry, which
    // is never the free slot nor a done head, so both writes may land in one cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            queue[wr_ptr] <= new_entry;
        end
        if (rsp_hit) begin
            queue[fifo_head].dst_color <= mem_rsp_data;
            queue[fifo_head].done      <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_valid <= 1'b0;
            req_addr  <= '0;
            req_idx   <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + IDX_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + IDX_W'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // in_ready guarantees the register is empty or firing when reloaded.
            if (accept && in_read_en) begin
                req_valid <= 1'b1;
                req_addr  <= addr_calc;
                req_idx   <= wr_ptr;
            end else if (req_fire) begin
                req_valid <= 1'b0;
            end
        end
    end

    om_dst_index_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .IDX_W (IDX_W)
    ) u_index_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (req_fire),
        .push_idx (req_idx),
        .pop      (rsp_hit),
        .head_idx (fifo_head),
        .empty    (fifo_empty)
    );

    // Data outputs read as zero whenever nothing is being presented.
    assign out_pos_x     = out_valid ? head.pos_x     : '0;
    assign out_pos_y     = out_valid ? head.pos_y     : '0;
    assign out_src_color = out_valid ? head.src_color : '0;
    assign out_dst_color = out_valid ? head.dst_color : '0;
    assign out_tag       = out_valid ? head.tag       : '0;

endmodule

// File: tb/tb_om_dst_fetch.sv
// Self-checking bench for om_dst_fetch: table of fragments plus hand-written
// sequences for ordering, back-pressure, request stall and reset corner cases.
module tb_om_dst_fetch;
    import om_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cbuf_addr;
    logic [15:0] cbuf_pitch;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_pos_x, in_pos_y;
    logic [31:0] in_src_color;
    logic        in_read_en;
    logic [7:0]  in_tag;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data  = '0;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_pos_x, out_pos_y;
    logic [31:0] out_src_color, out_dst_color;
    logic [7:0]  out_tag;

    om_dst_fetch dut (
        .clk(clk), .reset(reset), .cbuf_addr(cbuf_addr), .cbuf_pitch(cbuf_pitch),
        .in_valid(in_valid), .in_ready(in_ready), .in_pos_x(in_pos_x), .in_pos_y(in_pos_y),
        .in_src_color(in_src_color), .in_read_en(in_read_en), .in_tag(in_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pos_x(out_pos_x), .out_pos_y(out_pos_y),
        .out_src_color(out_src_color), .out_dst_color(out_dst_color), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] x, y;
        logic [31:0] src;
        logic        rd;
        logic [7:0]  tag;
        logic [31:0] exp_addr;
        logic [31:0] exp_dst;
    } vec_t;

    typedef struct {
        logic [11:0] x, y;
        logic [31:0] src, dst;
        logic [7:0]  tag;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    exp_t        sb[$];
    logic [31:0] addr_q[$];
    rsp_t        mem_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int req_count = 0;
    int last_rsp_cyc = 0;
    int rsp_delay = 2;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC2C43EF9;
    endfunction

    function automatic vec_t mk(input logic [11:0] x, input logic [11:0] y,
                                input logic [31:0] src, input logic rd, input logic [7:0] tag);
        vec_t v;
        logic [63:0] t;
        t = 64'(cbuf_addr) + 64'(y) * 64'(cbuf_pitch) + 64'(x) * 64'd4;
        v.x = x; v.y = y; v.src = src; v.rd = rd; v.tag = tag;
        v.exp_addr = t[31:0];
        v.exp_dst  = rd ? mem_data(t[31:0]) : 32'h0;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.x = v.x; e.y = v.y; e.src = v.src; e.dst = v.exp_dst; e.tag = v.tag;
        sb.push_back(e);
        if (v.rd) addr_q.push_back(v.exp_addr);
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_pos_x = v.x; in_pos_y = v.y; in_src_color = v.src;
        in_read_en = v.rd; in_tag = v.tag;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input vec_t v);
        int  waited = 0;
        bit  ok = 0;
        drive(v);
        while (!ok && waited < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else begin
                @(posedge clk);
                #1;
                waited++;
            end
        end
        if (!ok) begin
            fail_timeout("send");
            in_valid = 1'b0;
            return;
        end
        push_exp(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((sb.size() != 0 || addr_q.size() != 0 || mem_q.size() != 0) && w < 300) begin
            step(1);
            w++;
        end
        if (w >= 300) fail_timeout("drain");
        step(1);
    endtask

    // Memory model: checks request addresses, returns responses in order after rsp_delay.
    always @(negedge clk) begin
        if (mem_req_valid && mem_req_ready) begin
            req_count++;
            if (addr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL req_unexpected: got addr 0x%0h with none expected", mem_req_addr);
            end else begin
                check("req_addr", mem_req_addr, addr_q.pop_front());
            end
            mem_q.push_back('{cyc + rsp_delay, mem_data(mem_req_addr)});
        end
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_q[0].data;
            last_rsp_cyc  = cyc;
            void'(mem_q.pop_front());
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    end

    // Output monitor: scoreboard compare on handshake, stability while stalled.
    bit   hold_v = 0;
    exp_t hold_d;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("out_hold_valid", out_valid, 1'b1);
                check("out_hold_data", {out_src_color, out_dst_color},
                      {hold_d.src, hold_d.dst});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_unexpected: got tag 0x%0h with none expected", out_tag);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_x", out_pos_x, mon_e.x);
                    check("out_y", out_pos_y, mon_e.y);
                    check("out_src", out_src_color, mon_e.src);
                    check("out_dst", out_dst_color, mon_e.dst);
                    check("out_tag", out_tag, mon_e.tag);
                end
                hold_v = 0;
            end else if (out_valid) begin
                hold_v = 1;
                hold_d.x = out_pos_x; hold_d.y = out_pos_y; hold_d.src = out_src_color;
                hold_d.dst = out_dst_color; hold_d.tag = out_tag;
            end else begin
                hold_v = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t v;
        int   rc;
        bit   seen;

        reset = 1'b0; in_valid = 1'b0; in_pos_x = '0; in_pos_y = '0;
        in_src_color = '0; in_read_en = 1'b0; in_tag = '0;
        out_ready = 1'b0; mem_req_ready = 1'b1;
        cbuf_addr = 32'h1000; cbuf_pitch = 16'h0400;

        //            x        y        src            rd    tag    addr          dst
        vecs[0] = '{12'd3,   12'd2,   32'h12345678, 1'b1, 8'h01, 32'h0000180C, 32'hC2C426F5};
        vecs[1] = '{12'd0,   12'd0,   32'hDEADBEEF, 1'b0, 8'h02, 32'h00000000, 32'h00000000};
        vecs[2] = '{12'hFFF, 12'hFFF, 32'hCAFEF00D, 1'b1, 8'h03, 32'h00404BFC, 32'hC2847505};
        vecs[3] = '{12'd1,   12'd0,   32'h0BADF00D, 1'b1, 8'h04, 32'h00001004, 32'hC2C42EFD};
        vecs[4] = '{12'd5,   12'd7,   32'hFFFFFFFF, 1'b0, 8'hFF, 32'h00000000, 32'h00000000};
        vecs[5] = '{12'h10,  12'd1,   32'h00000001, 1'b1, 8'h00, 32'h00001440, 32'hC2C42AB9};

        // Reset state
        step(3);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        check("rst_out_data", {out_src_color, out_dst_color, out_tag}, 72'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_reset", in_ready, 1'b1);
        @(posedge clk); #1;

        // Table vectors streamed back to back
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(vecs[i]);
        drain();

        // No-read fragment on empty queue: out_valid the cycle after accept, no request
        rc = req_count;
        v = mk(12'd7, 12'd9, 32'h11223344, 1'b0, 8'h22);
        drive(v);
        @(negedge clk);
        check("noread_accept", in_ready, 1'b1);
        push_exp(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("noread_latency", out_valid, 1'b1);
        check("noread_no_req", mem_req_valid, 1'b0);
        @(posedge clk); #1;
        drain();
        check("noread_req_count", req_count, rc);

        // Order: slow read A followed by no-read B; B must wait
        rsp_delay = 10;
        send(mk(12'd2, 12'd3, 32'hAAAA0001, 1'b1, 8'hA1));
        send(mk(12'd4, 12'd5, 32'hBBBB0002, 1'b0, 8'hB2));
        repeat (6) begin
            @(negedge clk);
            check("order_hold", out_valid, 1'b0);
            @(posedge clk); #1;
        end
        seen = 0;
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!seen) fail_timeout("rsp_latency");
        else check("rsp_latency", cyc, last_rsp_cyc + 1);
        @(posedge clk); #1;
        drain();

        // Back-pressure: 4 fill the queue, 5th waits until a pop frees a slot
        rsp_delay = 2;
        out_ready = 1'b0;
        send(mk(12'd1, 12'd1, 32'h40000001, 1'b1, 8'h41));
        send(mk(12'd2, 12'd1, 32'h40000002, 1'b0, 8'h42));
        send(mk(12'd3, 12'd1, 32'h40000003, 1'b1, 8'h43));
        send(mk(12'd4, 12'd1, 32'h40000004, 1'b0, 8'h44));
        v = mk(12'd5, 12'd1, 32'h40000005, 1'b1, 8'h45);
        drive(v);
        repeat (6) begin
            @(negedge clk);
            check("full_block", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("full_head_done", out_valid, 1'b1);
        check("no_bypass", in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("slot_freed", in_ready, 1'b1);
        push_exp(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Memory stalls a request for 6 cycles
        mem_req_ready = 1'b0;
        rc = req_count;
        v = mk(12'd6, 12'd2, 32'h50000001, 1'b1, 8'h51);
        send(v);
        repeat (6) begin
            @(negedge clk);
            check("req_hold_valid", mem_req_valid, 1'b1);
            check("req_hold_addr", mem_req_addr, v.exp_addr);
            check("req_stall_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b1;
        step(4);
        check("single_req", req_count - rc, 1);
        drain();

        // Address wraps modulo 2^32
        cbuf_addr = 32'hFFFFFFF0;
        cbuf_pitch = 16'h0100;
        send('{12'd8, 12'd0, 32'h70000001, 1'b1, 8'h71, 32'h00000010, 32'hC2C43EE9});
        send('{12'd0, 12'd1, 32'h70000002, 1'b1, 8'h72, 32'h000000F0, 32'hC2C43E09});
        drain();
        cbuf_addr = 32'h1000;
        cbuf_pitch = 16'h0400;

        // Reset with two reads in flight; their late responses must be dropped
        rsp_delay = 20;
        rc = req_count;
        send(mk(12'd1, 12'd2, 32'h60000001, 1'b1, 8'h61));
        send(mk(12'd3, 12'd4, 32'h60000002, 1'b1, 8'h62));
        for (int w = 0; w < 20 && (req_count - rc) < 2; w++) step(1);
        check("rst_reqs_issued", req_count - rc, 2);
        reset = 1'b0;
        sb.delete();
        addr_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("midrst_in_ready", in_ready, 1'b0);
            check("midrst_out_valid", out_valid, 1'b0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        for (int w = 0; w < 60 && mem_q.size() != 0; w++) begin
            @(negedge clk);
            check("stale_drop", out_valid, 1'b0);
            @(posedge clk); #1;
        end
        step(2);
        @(negedge clk);
        check("stale_after", out_valid, 1'b0);
        @(posedge clk); #1;
        rsp_delay = 3;
        send(mk(12'd9, 12'd9, 32'h60000003, 1'b1, 8'h63));
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
